// File: rtl/pulse_params_pkg.sv
// Shared pulse-parameter definitions: frame constants, field layout and byte helpers
// used by both the parameter report transmitter and the command receiver.
package pulse_params_pkg;

    localparam logic [7:0] PKT_HDR     = 8'hA5;
    localparam int         FRAME_LEN   = 20;
    localparam int         PAYLOAD_LEN = 18;

    localparam int PERIOD_W          = 32;
    localparam int P1WIDTH_W         = 16;
    localparam int DELAY_W           = 16;
    localparam int P2WIDTH_W         = 16;
    localparam int NUT_DEL_W         = 16;
    localparam int NUT_WID_W         = 8;
    localparam int PULSE_BLOCK_W     = 8;
    localparam int PULSE_BLOCK_OFF_W = 16;
    localparam int CPMG_W            = 8;
    localparam int BLK_W             = 8;

    // Member order is wire order; packing MSB-first makes byte k of the payload
    // simply the k-th byte from the top of the flattened struct.
    typedef struct packed {
        logic [PERIOD_W-1:0]          period;
        logic [P1WIDTH_W-1:0]         p1width;
        logic [DELAY_W-1:0]           delay;
        logic [P2WIDTH_W-1:0]         p2width;
        logic [NUT_DEL_W-1:0]         nut_del;
        logic [NUT_WID_W-1:0]         nut_wid;
        logic [PULSE_BLOCK_W-1:0]     pulse_block;
        logic [PULSE_BLOCK_OFF_W-1:0] pulse_block_off;
        logic [CPMG_W-1:0]            cpmg;
        logic [BLK_W-1:0]             blk;
    } pulse_params_t;

    localparam int PARAMS_W = $bits(pulse_params_t);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, NEXT, FINISH} tx_state_t;

    function automatic logic [7:0] payload_byte(input pulse_params_t p, input logic [4:0] idx);
        logic [PARAMS_W-1:0] flat;
        flat = p;
        flat = flat << (8 * idx);
        return flat[PARAMS_W-1 -: 8];
    endfunction

    function automatic logic [7:0] payload_sum(input pulse_params_t p);
        logic [PARAMS_W-1:0] flat;
        logic [7:0]          sum;
        flat = p;
        sum  = 8'h00;
        for (int i = 0; i < PAYLOAD_LEN; i++) begin
            sum  = sum + flat[PARAMS_W-1 -: 8];
            flat = flat << 8;
        end
        return sum;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer. ready is high when idle and during the last cycle
// of the stop bit, so a byte offered then starts with no idle gap.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        BIT_STOP  = 4'd9;

    logic              active;
    logic [3:0]        bit_idx;
    logic [BAUD_W-1:0] baud_cnt;
    logic [8:0]        shreg;
    logic              bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign ready   = !active || ((bit_idx == BIT_STOP) && bit_end);

    // shreg holds the bits still to go out with the stop bit on top; ones shift
    // in behind it so the line rests high once the byte is finished.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            active   <= 1'b0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else if (valid && ready) begin
            active   <= 1'b1;
            bit_idx  <= '0;
            baud_cnt <= '0;
            shreg    <= {1'b1, data};
            tx       <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                tx       <= shreg[0];
                shreg    <= {1'b1, shreg[8:1]};
                if (bit_idx == BIT_STOP) begin
                    active  <= 1'b0;
                    bit_idx <= '0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_report_tx.sv
// Sends a snapshot of the current pulse parameters over the UART as a
// 20-byte frame: header, 18 payload bytes, 8-bit additive checksum.
module param_report_tx
    import pulse_params_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 104,
    parameter logic [7:0] HDR_BYTE     = PKT_HDR
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] period,
    input  logic [15:0] p1width,
    input  logic [15:0] delay,
    input  logic [15:0] p2width,
    input  logic [15:0] nut_del,
    input  logic [7:0]  nut_wid,
    input  logic [7:0]  pulse_block,
    input  logic [15:0] pulse_block_off,
    input  logic [7:0]  cpmg,
    input  logic        block,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST_IDX  = 5'(FRAME_LEN - 1);
    localparam logic [4:0] CSUM_PREV = 5'(FRAME_LEN - 2);

    tx_state_t     state;
    pulse_params_t snap;
    pulse_params_t live;
    logic [7:0]    csum;
    logic [4:0]    byte_idx;
    logic          accept;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;

    assign live = '{
        period:          period,
        p1width:         p1width,
        delay:           delay,
        p2width:         p2width,
        nut_del:         nut_del,
        nut_wid:         nut_wid,
        pulse_block:     pulse_block,
        pulse_block_off: pulse_block_off,
        cpmg:            cpmg,
        blk:             {7'd0, block}
    };

    // busy is low only in IDLE and FINISH, so a chained start in the done cycle is taken.
    assign accept = resetn && start && !busy;

    // The header goes out on the accepting edge itself; every later byte is
    // handed over in the last stop-bit cycle of the byte currently on the wire.
    always_comb begin
        byte_valid = 1'b0;
        byte_data  = HDR_BYTE;
        if (accept) begin
            byte_valid = 1'b1;
        end else if (state == SEND && byte_ready && byte_idx != LAST_IDX) begin
            byte_valid = 1'b1;
            byte_data  = (byte_idx == CSUM_PREV) ? csum : payload_byte(snap, byte_idx);
        end
    end

    // byte_idx names the byte currently being serialized.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            snap     <= '0;
            csum     <= '0;
            byte_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                snap     <= live;
                byte_idx <= '0;
                busy     <= 1'b1;
                state    <= LOAD;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    LOAD: begin
                        csum  <= payload_sum(snap);
                        state <= SEND;
                    end
                    SEND: begin
                        if (byte_ready) begin
                            if (byte_idx == LAST_IDX) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= FINISH;
                            end else begin
                                state <= NEXT;
                            end
                        end
                    end
                    NEXT: begin
                        byte_idx <= byte_idx + 5'd1;
                        state    <= SEND;
                    end
                    FINISH:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk   (clk),
        .resetn(resetn),
        .valid (byte_valid),
        .data  (byte_data),
        .ready (byte_ready),
        .tx    (tx)
    );

endmodule

// File: tb/tb_param_report_tx.sv
// Bench for param_report_tx: a serial-line receiver decodes tx independently and
// frames are compared against a byte-list model of the report format.
module tb_param_report_tx;

    localparam int CPB       = 13;
    localparam int FRAME_CYC = 200 * CPB;

    typedef logic [7:0] frame_t [20];

    typedef struct {
        logic [31:0] period;
        logic [15:0] p1width;
        logic [15:0] delay;
        logic [15:0] p2width;
        logic [15:0] nut_del;
        logic [7:0]  nut_wid;
        logic [7:0]  pulse_block;
        logic [15:0] pulse_block_off;
        logic [7:0]  cpmg;
        logic        block;
    } prm_t;

    typedef struct {
        string        name;
        prm_t         p;
        logic [159:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] period;
    logic [15:0] p1width, delay, p2width, nut_del, pulse_block_off;
    logic [7:0]  nut_wid, pulse_block, cpmg;
    logic        block;
    logic        tx, busy, done;

    int   cyc = 0;
    int   ncmp = 0;
    int   nfail = 0;
    bit   mon_en = 1'b1;
    logic [7:0] rx_q[$];
    int         rx_t[$];
    bit         rx_ok[$];
    int         done_q[$];

    param_report_tx #(
        .CLKS_PER_BIT(CPB),
        .HDR_BYTE    (8'hA5)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .start          (start),
        .period         (period),
        .p1width        (p1width),
        .delay          (delay),
        .p2width        (p2width),
        .nut_del        (nut_del),
        .nut_wid        (nut_wid),
        .pulse_block    (pulse_block),
        .pulse_block_off(pulse_block_off),
        .cpmg           (cpmg),
        .block          (block),
        .tx             (tx),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_q.push_back(cyc);

    // Serial receiver: every bit must hold its value for exactly CPB cycles.
    initial begin
        int   s;
        bit   ok, aborted;
        logic bitv [10];
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                s = cyc; ok = 1'b1; aborted = 1'b0;
                for (int c = 0; c < 10 * CPB; c++) begin
                    if (c > 0) @(negedge clk);
                    if (!mon_en) begin aborted = 1'b1; break; end
                    if (c % CPB == 0) bitv[c / CPB] = tx;
                    else if (tx !== bitv[c / CPB]) ok = 1'b0;
                end
                if (!aborted) begin
                    if (bitv[0] !== 1'b0 || bitv[9] !== 1'b1) ok = 1'b0;
                    for (int k = 0; k < 8; k++) d[k] = bitv[k + 1];
                    rx_q.push_back(d); rx_t.push_back(s); rx_ok.push_back(ok);
                end
            end
        end
    end

    function automatic prm_t mk_prm(logic [31:0] per, logic [15:0] p1, logic [15:0] dl,
                                    logic [15:0] p2, logic [15:0] nd, logic [7:0] nw,
                                    logic [7:0] pb, logic [15:0] pbo, logic [7:0] cp, logic bl);
        prm_t p;
        p.period = per; p.p1width = p1; p.delay = dl; p.p2width = p2; p.nut_del = nd;
        p.nut_wid = nw; p.pulse_block = pb; p.pulse_block_off = pbo; p.cpmg = cp; p.block = bl;
        return p;
    endfunction

    function automatic prm_t rand_prm();
        return mk_prm($urandom, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                      8'($urandom), 8'($urandom), 16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    endfunction

    // Reference: header, each field MSB byte first, then the payload sum.
    function automatic frame_t model(input prm_t p);
        frame_t      f;
        logic [31:0] v [10];
        int          w [10];
        int          n;
        logic [7:0]  s;
        v = '{p.period, 32'(p.p1width), 32'(p.delay), 32'(p.p2width), 32'(p.nut_del),
              32'(p.nut_wid), 32'(p.pulse_block), 32'(p.pulse_block_off), 32'(p.cpmg), 32'(p.block)};
        w = '{4, 2, 2, 2, 2, 1, 1, 2, 1, 1};
        f[0] = 8'hA5; n = 1; s = 8'h00;
        for (int i = 0; i < 10; i++)
            for (int b = w[i] - 1; b >= 0; b--) begin
                f[n] = 8'(v[i] >> (8 * b));
                s = s + f[n];
                n++;
            end
        f[19] = s;
        return f;
    endfunction

    function automatic frame_t unpack(input logic [159:0] e);
        frame_t f;
        for (int i = 0; i < 20; i++) f[i] = e[159 - 8 * i -: 8];
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        ncmp++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic apply(input prm_t p);
        period = p.period; p1width = p.p1width; delay = p.delay; p2width = p.p2width;
        nut_del = p.nut_del; nut_wid = p.nut_wid; pulse_block = p.pulse_block;
        pulse_block_off = p.pulse_block_off; cpmg = p.cpmg; block = p.block;
    endtask

    task automatic start_frame(input string name);
        rx_q.delete(); rx_t.delete(); rx_ok.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " busy after accept"}, 64'(busy), 64'd1);
        check({name, " tx start bit after accept"}, 64'(tx), 64'd0);
    endtask

    task automatic wait_done(input string name, output int dc);
        dc = -1;
        for (int i = 0; i < FRAME_CYC + 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin dc = cyc; break; end
        end
        if (dc < 0) begin
            ncmp++; nfail++;
            $display("FAIL %s done timeout: got no done, expected one within %0d cycles", name, FRAME_CYC + 40);
        end else begin
            check({name, " busy low with done"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic check_frame(input string name, input frame_t f, input int dc);
        check({name, " byte count"}, 64'(rx_q.size()), 64'd20);
        for (int i = 0; i < 20 && i < rx_q.size(); i++) begin
            check($sformatf("%s byte%0d", name, i), 64'(rx_q[i]), 64'(f[i]));
            check($sformatf("%s bit timing byte%0d", name, i), 64'(rx_ok[i]), 64'd1);
            if (i > 0) check($sformatf("%s gap byte%0d", name, i), 64'(rx_t[i] - rx_t[0]), 64'(i * 10 * CPB));
        end
        if (rx_q.size() > 0 && dc >= 0)
            check({name, " done delay"}, 64'(dc - rx_t[0]), 64'(FRAME_CYC));
    endtask

    vec_t   vecs [4];
    frame_t fexp;
    prm_t   p, p2;
    int     dc, dc_prev, n0;

    initial begin
        vecs[0] = '{name: "default",
                    p: mk_prm(32'h00040000, 16'd30, 16'd200, 16'd60, 16'd100, 8'd0, 8'd50, 16'd100, 8'd1, 1'b1),
                    exp: 160'hA5_00_04_00_00_00_1E_00_C8_00_3C_00_64_00_32_00_64_01_01_22};
        vecs[1] = '{name: "all_ones",
                    p: mk_prm(32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 16'hFFFF, 8'hFF, 1'b1),
                    exp: {8'hA5, {17{8'hFF}}, 8'h01, 8'hF0}};
        vecs[2] = '{name: "all_zero",
                    p: mk_prm(32'h0, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 16'h0, 8'h0, 1'b0),
                    exp: {8'hA5, {19{8'h00}}}};
        vecs[3] = '{name: "distinct",
                    p: mk_prm(32'h12345678, 16'h9ABC, 16'hDEF0, 16'h0011, 16'h2233, 8'h44, 8'h55, 16'h6677, 8'h88, 1'b0),
                    exp: 160'hA5_12_34_56_78_9A_BC_DE_F0_00_11_22_33_44_55_66_77_88_00_9C};

        resetn = 1'b0; start = 1'b0; apply(vecs[2].p);
        repeat (3) @(posedge clk); #1;
        check("reset tx", 64'(tx), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        @(negedge clk) resetn = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[v]) begin
            apply(vecs[v].p);
            start_frame(vecs[v].name);
            wait_done(vecs[v].name, dc);
            check_frame(vecs[v].name, unpack(vecs[v].exp), dc);
            @(negedge clk);
            check({vecs[v].name, " done width"}, 64'(done), 64'd0);
            repeat (5) @(negedge clk);
        end

        // Snapshot coherence, then a chained start in the done cycle
        apply(vecs[0].p);
        start_frame("snap1");
        repeat (3 * 10 * CPB + 4) @(negedge clk);
        p1width = 16'h1234;
        wait_done("snap1", dc);
        check_frame("snap1", unpack(vecs[0].exp), dc);
        dc_prev = dc;
        start_frame("chain");
        wait_done("chain", dc);
        p = vecs[0].p; p.p1width = 16'h1234;
        check_frame("chain", model(p), dc);
        if (rx_t.size() > 0) check("chain start cycle", 64'(rx_t[0]), 64'(dc_prev + 1));
        repeat (5) @(negedge clk);

        // Start pulses while busy are dropped
        p = rand_prm(); apply(p);
        n0 = done_q.size();
        start_frame("collide");
        repeat (61) @(negedge clk);
        start = 1'b1; apply(rand_prm()); @(negedge clk) start = 1'b0;
        repeat (1190) @(negedge clk);
        start = 1'b1; @(negedge clk) start = 1'b0;
        wait_done("collide", dc);
        check_frame("collide", model(p), dc);
        repeat (20 * CPB) @(negedge clk);
        check("collide done count", 64'(done_q.size() - n0), 64'd1);
        check("collide no extra frame", 64'(rx_q.size()), 64'd20);
        check("collide idle busy", 64'(busy), 64'd0);

        // Reset during byte 7, with start also high during reset
        p = rand_prm(); apply(p);
        start_frame("abort");
        repeat (7 * 10 * CPB + 5) @(negedge clk);
        mon_en = 1'b0; n0 = done_q.size();
        resetn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        check("abort tx high", 64'(tx), 64'd1);
        check("abort busy low", 64'(busy), 64'd0);
        @(negedge clk) begin resetn = 1'b1; start = 1'b0; end
        repeat (30 * CPB) @(negedge clk);
        check("abort no done", 64'(done_q.size() - n0), 64'd0);
        check("abort tx idle", 64'(tx), 64'd1);
        check("abort still idle", 64'(busy), 64'd0);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        p = rand_prm(); apply(p);
        start_frame("after_abort");
        wait_done("after_abort", dc);
        check_frame("after_abort", model(p), dc);

        // Randomized frames, odd ones chained off the previous done
        for (int r = 0; r < 4; r++) begin
            p2 = rand_prm(); apply(p2);
            if (r % 2 == 0) repeat ($urandom_range(2, 9)) @(negedge clk);
            start_frame($sformatf("rand%0d", r));
            p = rand_prm(); apply(p);
            wait_done($sformatf("rand%0d", r), dc);
            check_frame($sformatf("rand%0d", r), model(p2), dc);
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
